relu_block: RTL and testbench

- Registered, lane-parallel ReLU stage applied to the packed output vector of an ANN layer.
- Sits between a layer's accumulator/bias stage and the next layer's input or output buffer.
- Captures `relu(in)` while `layer_done` is high.
- Raises a sticky `done` flag for downstream sequencing.

---
 rtl/relu_pkg.sv | 19 +
 rtl/relu_lane.sv | 32 +++
 rtl/relu_block.sv | 68 ++++++
 tb/tb_relu_block.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/relu_pkg.sv
// relu_pkg: shared constants, FSM state type and lane-indexing helper
// for the registered lane-parallel ReLU stage.
package relu_pkg;

  localparam int unsigned DATAWIDTH = 11;
  localparam int unsigned ROWS      = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  // Base bit index of lane idx inside a packed vector of width-bit lanes.
  function automatic int unsigned lane_base(input int unsigned idx,
                                            input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/relu_lane.sv
// relu_lane: purely combinational single-lane ReLU.
// Optional macro RELU_CLAMP_EN turns it into a bounded ReLU that clips
// positive values above clamp_max; without it clamp_max is ignored.
module relu_lane #(
  parameter int unsigned datawidth = 11,
  parameter int          clamp_max = 255
) (
  input  logic signed [datawidth-1:0] din,
  output logic signed [datawidth-1:0] dout
);

`ifdef RELU_CLAMP_EN
  localparam logic signed [datawidth-1:0] CLAMP_V = datawidth'(clamp_max);
`endif

  // Sign bit set means negative (including the most-negative code): zero it.
  always_comb begin
    dout = '0;
    if (!din[datawidth-1]) begin
`ifdef RELU_CLAMP_EN
      if (din > CLAMP_V) begin
        dout = CLAMP_V;
      end else begin
        dout = din;
      end
`else
      dout = din;
`endif
    end
  end

endmodule

// File: rtl/relu_block.sv
// relu_block: registered lane-parallel ReLU applied to a layer's packed
// output vector. Captures relu(in) whenever layer_done is high and raises
// a sticky done flag that only rst_vals / rst_overall can clear.
// Optional macro RELU_CLAMP_EN selects a bounded ReLU (clip at clamp_max).
module relu_block
  import relu_pkg::*;
#(
  parameter int unsigned datawidth = DATAWIDTH,
  parameter int unsigned rows      = ROWS,
  parameter int          clamp_max = 255
) (
  input  logic                      clk,
  input  logic                      rst_overall,
  input  logic                      rst_vals,
  input  logic                      layer_done,
  input  logic [rows*datawidth-1:0] in,
  output logic [rows*datawidth-1:0] out,
  output logic                      done
);

  state_t                    state;
  logic [rows*datawidth-1:0] relu_vec;
  logic [rows*datawidth-1:0] out_q;

  for (genvar i = 0; i < rows; i++) begin : g_lane
    relu_lane #(
      .datawidth (datawidth),
      .clamp_max (clamp_max)
    ) u_lane (
      .din  (in[lane_base(i, datawidth) +: datawidth]),
      .dout (relu_vec[lane_base(i, datawidth) +: datawidth])
    );
  end

  // Capture FSM and output register; either reset clears values and done,
  // and layer_done is only honoured when no reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_overall) begin
      state <= IDLE;
      out_q <= '0;
    end else if (rst_vals) begin
      state <= IDLE;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (layer_done) begin
            out_q <= relu_vec;
            state <= VALID;
          end
        end
        VALID: begin
          if (layer_done) begin
            out_q <= relu_vec;
          end
        end
        default: begin
          state <= IDLE;
          out_q <= '0;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign done = (state == VALID);

endmodule

// File: tb/tb_relu_block.sv
// tb_relu_block: directed-vector self-checking bench for relu_block.
module tb_relu_block;

  localparam int unsigned DW = 11;
  localparam int unsigned RW = 4;
  localparam int unsigned VW = DW * RW;

  logic          clk;
  logic          rst_overall;
  logic          rst_vals;
  logic          layer_done;
  logic [VW-1:0] in;
  logic [VW-1:0] out;
  logic          done;

  int unsigned n_pass;
  int unsigned n_total;

  relu_block #(
    .datawidth (DW),
    .rows      (RW),
    .clamp_max (255)
  ) dut (
    .clk         (clk),
    .rst_overall (rst_overall),
    .rst_vals    (rst_vals),
    .layer_done  (layer_done),
    .in          (in),
    .out         (out),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pack4(input int a0, input int a1,
                                          input int a2, input int a3);
    logic [VW-1:0] r;
    r = '0;
    r[0*DW +: DW] = a0[DW-1:0];
    r[1*DW +: DW] = a1[DW-1:0];
    r[2*DW +: DW] = a2[DW-1:0];
    r[3*DW +: DW] = a3[DW-1:0];
    return r;
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, then advance one rising edge and sample
  // on the following falling edge.
  task automatic cycle();
    @(negedge clk);
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    rst_overall = 1'b1;
    rst_vals    = 1'b0;
    layer_done  = 1'b0;
    in          = '0;
    cycle();
    cycle();
    check("reset_out", out, '0);
    check("reset_done", {{(VW-1){1'b0}}, done}, '0);

    // First capture from IDLE
    rst_overall = 1'b0;
    layer_done  = 1'b1;
    in          = pack4(-15, 5, -2, 20);
    cycle();
    check("cap1_out", out, pack4(0, 5, 0, 20));
    check("cap1_done", {{(VW-1){1'b0}}, done}, VW'(1));

    // Tracking in VALID
    in = pack4(0, -1, 7, -8);
    cycle();
    check("cap2_out", out, pack4(0, 0, 7, 0));
    check("cap2_done", {{(VW-1){1'b0}}, done}, VW'(1));

    // Extreme codes
    in = pack4(-1024, 1023, -1, 1);
    cycle();
`ifdef RELU_CLAMP_EN
    check("bound_out", out, pack4(0, 255, 0, 1));
`else
    check("bound_out", out, pack4(0, 1023, 0, 1));
`endif

    // Around the clip threshold
    in = pack4(256, 255, 254, 0);
    cycle();
`ifdef RELU_CLAMP_EN
    check("clip_out", out, pack4(255, 255, 254, 0));
`else
    check("clip_out", out, pack4(256, 255, 254, 0));
`endif

    // Hold: capture then drop layer_done with garbage on in
    in = pack4(3, 4, 5, 6);
    cycle();
    check("hold_cap", out, pack4(3, 4, 5, 6));
    layer_done = 1'b0;
    in = pack4(-9, -9, -9, -9);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("hold_out", out, pack4(3, 4, 5, 6));
      check("hold_done", {{(VW-1){1'b0}}, done}, VW'(1));
      in = 'x;
    end

    // rst_vals wins over layer_done
    layer_done = 1'b1;
    rst_vals   = 1'b1;
    in         = pack4(10, 10, 10, 10);
    cycle();
    check("rv_out", out, '0);
    check("rv_done", {{(VW-1){1'b0}}, done}, '0);
    rst_vals = 1'b0;
    cycle();
    check("rv_resume_out", out, pack4(10, 10, 10, 10));
    check("rv_resume_done", {{(VW-1){1'b0}}, done}, VW'(1));

    // IDLE holds while layer_done is low
    rst_vals   = 1'b1;
    cycle();
    rst_vals   = 1'b0;
    layer_done = 1'b0;
    in         = pack4(7, 7, 7, 7);
    cycle();
    check("idle_out", out, '0);
    check("idle_done", {{(VW-1){1'b0}}, done}, '0);

    // Both resets during VALID, held for several cycles
    layer_done = 1'b1;
    in         = pack4(1, 2, 3, 4);
    cycle();
    check("pre_rst_out", out, pack4(1, 2, 3, 4));
    rst_overall = 1'b1;
    rst_vals    = 1'b1;
    in          = pack4(50, 60, 70, 80);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("both_rst_out", out, '0);
      check("both_rst_done", {{(VW-1){1'b0}}, done}, '0);
    end
    rst_overall = 1'b0;
    rst_vals    = 1'b0;
    cycle();
    check("post_rst_out", out, pack4(50, 60, 70, 80));
    check("post_rst_done", {{(VW-1){1'b0}}, done}, VW'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
